wb_regfile: RTL and testbench

//  Writeback stage plus architectural register file; consumes the MEM/WB pipeline register outputs.

---
 rtl/wb_regfile.sv | 96 +++++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: result select, x1..x31 storage,
// two decode read ports with optional same-cycle bypass, a debug port and a commit counter.
module wb_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_W,
    input  logic [1:0]        ResultSrc_W,
    input  logic [XLEN-1:0]   ALUResult_W,
    input  logic [XLEN-1:0]   ReadData_W,
    input  logic [XLEN-1:0]   PCTarget_W,
    input  logic [ADDR_W-1:0] Rd_W,
    input  logic [ADDR_W-1:0] A1_D,
    input  logic [ADDR_W-1:0] A2_D,
    output logic [XLEN-1:0]   RD1_D,
    output logic [XLEN-1:0]   RD2_D,
    output logic [XLEN-1:0]   Result_W,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [XLEN-1:0]   DbgData,
    output logic [CNT_W-1:0]  WbCount
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [XLEN-1:0]  r_regs [NREG];
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  w_result;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;
    logic [XLEN-1:0]  w_dbg;
    logic             w_commit;

    always_comb begin
        w_result = ALUResult_W;
        case (ResultSrc_W)
            2'b01:   w_result = ReadData_W;
            2'b10:   w_result = PCTarget_W;
            default: w_result = ALUResult_W;
        endcase
    end

    // Logical AND keeps an X on Rd_W from leaking into state while RegWrite_W is low.
    assign w_commit = RegWrite_W && (Rd_W != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[Rd_W] <= w_result;
            r_count      <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_rd1 = '0;
        if (A1_D != '0) begin
            if ((BYPASS != 0) && w_commit && (A1_D == Rd_W)) begin
                w_rd1 = w_result;
            end else begin
                w_rd1 = r_regs[A1_D];
            end
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (A2_D != '0) begin
            if ((BYPASS != 0) && w_commit && (A2_D == Rd_W)) begin
                w_rd2 = w_result;
            end else begin
                w_rd2 = r_regs[A2_D];
            end
        end
    end

    always_comb begin
        w_dbg = '0;
        if (DbgAddr != '0) begin
            w_dbg = r_regs[DbgAddr];
        end
    end

    assign Result_W = w_result;
    assign RD1_D    = w_rd1;
    assign RD2_D    = w_rd2;
    assign DbgData  = w_dbg;
    assign WbCount  = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing 32-bit-count instance and a
// non-bypassing 4-bit-count instance share the same stimulus.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [31:0] ALUResult_W;
    logic [31:0] ReadData_W;
    logic [31:0] PCTarget_W;
    logic [4:0]  Rd_W;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [4:0]  DbgAddr;

    logic [31:0] RD1_D, RD2_D, Result_W, DbgData, WbCount;
    logic [31:0] RD1_nb, RD2_nb, Result_nb, DbgData_nb;
    logic [3:0]  WbCount_nb;

    int n_vec;
    int n_miss;

    wb_regfile #(.XLEN(32), .ADDR_W(5), .BYPASS(1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCTarget_W(PCTarget_W),
        .Rd_W(Rd_W), .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
        .Result_W(Result_W), .DbgAddr(DbgAddr), .DbgData(DbgData), .WbCount(WbCount)
    );

    wb_regfile #(.XLEN(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) u_dut_nb (
        .clk(clk), .rst(rst), .RegWrite_W(RegWrite_W), .ResultSrc_W(ResultSrc_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCTarget_W(PCTarget_W),
        .Rd_W(Rd_W), .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_nb), .RD2_D(RD2_nb),
        .Result_W(Result_nb), .DbgAddr(DbgAddr), .DbgData(DbgData_nb), .WbCount(WbCount_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu, rdat, pct;
        logic [4:0]  rd, a1, a2, dbg;
        logic [31:0] e_res, e_rd1, e_rd2, e_dbg, e_rd1_nb, e_rd2_nb, e_cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        RegWrite_W  = 1'b0;
        ResultSrc_W = 2'b00;
        ALUResult_W = '0;
        ReadData_W  = '0;
        PCTarget_W  = '0;
        Rd_W        = '0;
    endtask

    logic [31:0] cnt4;

    initial begin
        n_vec  = 0;
        n_miss = 0;
        //            rw src alu           rdat    pct     rd a1 a2 dbg  res           rd1           rd2           dbg           rd1_nb        rd2_nb        cnt
        tbl[0] = '{1'b1, 2'd0, 32'h11,       32'h22, 32'h33, 5, 5, 0, 5, 32'h11,       32'h11,       32'h0,        32'h0,        32'h0,        32'h0,        32'd0};
        tbl[1] = '{1'b1, 2'd1, 32'h11,       32'h22, 32'h33, 6, 5, 6, 5, 32'h22,       32'h11,       32'h22,       32'h11,       32'h11,       32'h0,        32'd1};
        tbl[2] = '{1'b1, 2'd2, 32'h11,       32'h22, 32'h33, 7, 6, 7, 6, 32'h33,       32'h22,       32'h33,       32'h22,       32'h22,       32'h0,        32'd2};
        tbl[3] = '{1'b0, 2'd3, 32'h44,       32'h22, 32'h33, 7, 7, 5, 7, 32'h44,       32'h33,       32'h11,       32'h33,       32'h33,       32'h11,       32'd3};
        tbl[4] = '{1'b1, 2'd0, 32'hDEADBEEF, 32'h0,  32'h0,  0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'd3};
        tbl[5] = '{1'b0, 2'd0, 32'h0,        32'h0,  32'h0,  0, 5, 0, 0, 32'h0,        32'h11,       32'h0,        32'h0,        32'h11,       32'h0,        32'd3};
        tbl[6] = '{1'b1, 2'd0, 32'h00CAFE00, 32'h0,  32'h0,  9, 9, 9, 9, 32'h00CAFE00, 32'h00CAFE00, 32'h00CAFE00, 32'h0,        32'h0,        32'h0,        32'd3};
        tbl[7] = '{1'b0, 2'd0, 32'h0,        32'h0,  32'h0,  9, 9, 9, 9, 32'h0,        32'h00CAFE00, 32'h00CAFE00, 32'h00CAFE00, 32'h00CAFE00, 32'h00CAFE00, 32'd4};

        rst = 1'b0;
        idle();
        A1_D = '0; A2_D = '0; DbgAddr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < 32; a++) begin
            A1_D = 5'(a); A2_D = 5'(31 - a); DbgAddr = 5'(a);
            #1;
            chk("reset_rd1", RD1_D, 32'h0);
            chk("reset_rd2", RD2_D, 32'h0);
            chk("reset_dbg", DbgData, 32'h0);
            @(negedge clk);
        end
        chk("reset_cnt", WbCount, 32'd0);
        chk("reset_cnt4", {28'h0, WbCount_nb}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            RegWrite_W = tbl[i].rw;  ResultSrc_W = tbl[i].src;
            ALUResult_W = tbl[i].alu; ReadData_W = tbl[i].rdat; PCTarget_W = tbl[i].pct;
            Rd_W = tbl[i].rd; A1_D = tbl[i].a1; A2_D = tbl[i].a2; DbgAddr = tbl[i].dbg;
            #2;
            cnt4 = tbl[i].e_cnt & 32'hF;
            chk($sformatf("v%0d_result", i), Result_W, tbl[i].e_res);
            chk($sformatf("v%0d_rd1", i), RD1_D, tbl[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), RD2_D, tbl[i].e_rd2);
            chk($sformatf("v%0d_dbg", i), DbgData, tbl[i].e_dbg);
            chk($sformatf("v%0d_rd1_nobyp", i), RD1_nb, tbl[i].e_rd1_nb);
            chk($sformatf("v%0d_rd2_nobyp", i), RD2_nb, tbl[i].e_rd2_nb);
            chk($sformatf("v%0d_cnt", i), WbCount, tbl[i].e_cnt);
            chk($sformatf("v%0d_cnt4", i), {28'h0, WbCount_nb}, cnt4);
        end

        // X on select/destination while not writing must leave state alone
        @(negedge clk);
        RegWrite_W = 1'b0; ResultSrc_W = 2'bxx; Rd_W = 5'bxxxxx;
        A1_D = 5'd9; A2_D = 5'd6; DbgAddr = 5'd5;
        @(negedge clk);
        #2;
        chk("xin_cnt", WbCount, 32'd4);
        chk("xin_rd1", RD1_D, 32'h00CAFE00);
        chk("xin_rd2", RD2_D, 32'h22);
        chk("xin_dbg", DbgData, 32'h11);

        // Reset asserted between edges while a second write is pending
        idle();
        RegWrite_W = 1'b1; Rd_W = 5'd3; ALUResult_W = 32'h55;
        @(negedge clk);
        Rd_W = 5'd4; ALUResult_W = 32'h66; DbgAddr = 5'd3;
        #1;
        chk("midrst_x3_pre", DbgData, 32'h55);
        rst = 1'b0;
        #1;
        chk("midrst_x3_async", DbgData, 32'h0);
        chk("midrst_cnt_async", WbCount, 32'd0);
        chk("midrst_result", Result_W, 32'h66);
        @(negedge clk);
        rst = 1'b1;
        idle();
        DbgAddr = 5'd4;
        #1;
        chk("midrst_x4", DbgData, 32'h0);
        DbgAddr = 5'd3;
        #1;
        chk("midrst_x3", DbgData, 32'h0);
        chk("midrst_cnt", WbCount, 32'd0);
        chk("midrst_cnt4", {28'h0, WbCount_nb}, 32'd0);

        // 17 commits wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            RegWrite_W = 1'b1; Rd_W = 5'd1; ResultSrc_W = 2'b00; ALUResult_W = 32'(100 + i);
        end
        @(negedge clk);
        idle();
        DbgAddr = 5'd1;
        #2;
        chk("wrap_cnt", WbCount, 32'd17);
        chk("wrap_cnt4", {28'h0, WbCount_nb}, 32'd1);
        chk("wrap_x1", DbgData, 32'd116);
        repeat (16) @(negedge clk);
        #2;
        chk("hold_cnt", WbCount, 32'd17);
        chk("hold_cnt4", {28'h0, WbCount_nb}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
